// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM command-port arbiter.
package dram_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } arb_state_e;

    localparam int unsigned DefAdxW  = 27;
    localparam int unsigned DefDataW = 128;
    localparam int unsigned CreditW  = 4;
    localparam int unsigned BurstW   = 8;

endpackage

// File: rtl/dram_rd_credit.sv
// Outstanding-read credit counter: up on read accept, down on data return, sticky underflow flag.
module dram_rd_credit
    import dram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [CreditW-1:0] count,
    output logic               at_limit,
    output logic               credit_err
);

    logic [CreditW-1:0] count_q, count_d;
    logic               err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc && !dec) begin
            if (count_q != '1) count_d = count_q + CreditW'(1);
        end else if (dec && !inc) begin
            // A return with nothing outstanding is a requester bug; hold at zero and flag it.
            if (count_q == '0) err_d = 1'b1;
            else               count_d = count_q - CreditW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign at_limit   = (count_q >= CreditW'(MAX_OUT));
    assign credit_err = err_q;

endmodule

// File: rtl/dram_req_arbiter.sv
// Write-priority arbiter for the DDR2 command port with read starvation limit and read credits.
module dram_req_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned ADX_W              = DefAdxW,
    parameter int unsigned DATA_W             = DefDataW,
    parameter int unsigned WR_BURST_MAX       = 8,
    parameter int unsigned RD_OUTSTANDING_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_req,
    input  logic [ADX_W-1:0]   wr_adx,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    input  logic               rd_req,
    input  logic [ADX_W-1:0]   rd_adx,
    output logic               rd_ack,
    input  logic               rd_return,
    output logic               mem_cmd_valid,
    input  logic               mem_cmd_ready,
    output logic               mem_cmd_write,
    output logic [ADX_W-1:0]   mem_cmd_adx,
    output logic [DATA_W-1:0]  mem_cmd_data,
    output logic [CreditW-1:0] rd_outstanding,
    output logic               credit_err,
    output logic               busy
);

    arb_state_e        state_q, state_d;
    logic [ADX_W-1:0]  adx_q;
    logic [DATA_W-1:0] data_q;
    logic              write_q;
    logic              wr_ack_q, rd_ack_q;
    logic [BurstW-1:0] burst_q, burst_d;

    logic rd_at_limit;
    logic wr_elig, rd_elig, rd_win;
    logic wr_grant, rd_grant, rd_accept;

    always_comb begin
        wr_elig  = wr_req;
        rd_elig  = rd_req && !rd_at_limit;
        // Reads win only when writes are absent or have used up their burst allowance.
        rd_win   = rd_elig && (!wr_elig || (burst_q >= BurstW'(WR_BURST_MAX)));
        wr_grant = (state_q == StIdle) && wr_elig && !rd_win;
        rd_grant = (state_q == StIdle) && rd_win;

        state_d = state_q;
        unique case (state_q)
            StIdle: if (wr_grant || rd_grant) state_d = StHold;
            StHold: if (mem_cmd_ready)        state_d = StIdle;
        endcase

        burst_d = burst_q;
        if (rd_grant || !rd_req) begin
            burst_d = '0;
        end else if (wr_grant && (burst_q != '1)) begin
            burst_d = burst_q + BurstW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            adx_q    <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= wr_grant;
            rd_ack_q <= rd_grant;
            burst_q  <= burst_d;
            if (wr_grant) begin
                adx_q   <= wr_adx;
                data_q  <= wr_data;
                write_q <= 1'b1;
            end else if (rd_grant) begin
                adx_q   <= rd_adx;
                write_q <= 1'b0;
            end
        end
    end

    assign mem_cmd_valid = (state_q == StHold);
    assign mem_cmd_write = write_q;
    assign mem_cmd_adx   = adx_q;
    assign mem_cmd_data  = data_q;
    assign wr_ack        = wr_ack_q;
    assign rd_ack        = rd_ack_q;
    assign rd_accept     = mem_cmd_valid && mem_cmd_ready && !write_q;

    dram_rd_credit #(
        .MAX_OUT (RD_OUTSTANDING_MAX)
    ) u_rd_credit (
        .clk        (clk),
        .reset      (reset),
        .inc        (rd_accept),
        .dec        (rd_return),
        .count      (rd_outstanding),
        .at_limit   (rd_at_limit),
        .credit_err (credit_err)
    );

    assign busy = mem_cmd_valid || (rd_outstanding != '0);

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Randomized scoreboard bench for dram_req_arbiter against a queue/integer reference model.
module tb_dram_req_arbiter;

    localparam int AW   = 27;
    localparam int DW   = 128;
    localparam int WRB  = 8;
    localparam int RDMX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_adx = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_adx = '0;
    logic          rd_ack;
    logic          rd_return = 1'b0;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b0;
    logic          mem_cmd_write;
    logic [AW-1:0] mem_cmd_adx;
    logic [DW-1:0] mem_cmd_data;
    logic [3:0]    rd_outstanding;
    logic          credit_err;
    logic          busy;

    always #5 clk = ~clk;

    dram_req_arbiter #(
        .ADX_W              (AW),
        .DATA_W             (DW),
        .WR_BURST_MAX       (WRB),
        .RD_OUTSTANDING_MAX (RDMX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_req         (wr_req),
        .wr_adx         (wr_adx),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .rd_req         (rd_req),
        .rd_adx         (rd_adx),
        .rd_ack         (rd_ack),
        .rd_return      (rd_return),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_write  (mem_cmd_write),
        .mem_cmd_adx    (mem_cmd_adx),
        .mem_cmd_data   (mem_cmd_data),
        .rd_outstanding (rd_outstanding),
        .credit_err     (credit_err),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit            write;
        logic [AW-1:0] adx;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t exp_q[$];

    // Reference model state, valid for the DUT after the coming posedge.
    bit m_hold = 0, m_cur_write = 0, m_err = 0, m_wr_ack = 0, m_rd_ack = 0;
    int m_burst = 0, m_out = 0;

    always @(negedge clk) begin
        bit acc, we, re, rw, wg, inc;
        chk("mem_cmd_valid", mem_cmd_valid, m_hold);
        chk("wr_ack", wr_ack, m_wr_ack);
        chk("rd_ack", rd_ack, m_rd_ack);
        chk("rd_outstanding", rd_outstanding, m_out);
        chk("credit_err", credit_err, m_err);
        chk("busy", busy, m_hold || (m_out != 0));
        if (reset) begin
            m_hold = 0; m_cur_write = 0; m_err = 0; m_wr_ack = 0; m_rd_ack = 0;
            m_burst = 0; m_out = 0;
        end else begin
            acc = m_hold && mem_cmd_ready;
            we = 0; re = 0; rw = 0; wg = 0;
            if (!m_hold) begin
                we = wr_req;
                re = rd_req && (m_out < RDMX);
                rw = re && (!we || (m_burst >= WRB));
                wg = we && !rw;
            end
            inc = acc && !m_cur_write;
            if (inc && !rd_return) m_out++;
            else if (rd_return && !inc) begin
                if (m_out == 0) m_err = 1;
                else m_out--;
            end
            if (rw || !rd_req) m_burst = 0;
            else if (wg && m_burst < 255) m_burst++;
            if (wg) begin
                exp_q.push_back('{write: 1'b1, adx: wr_adx, data: wr_data});
                m_cur_write = 1;
            end
            if (rw) begin
                exp_q.push_back('{write: 1'b0, adx: rd_adx, data: '0});
                m_cur_write = 0;
            end
            m_wr_ack = wg;
            m_rd_ack = rw;
            m_hold   = m_hold ? !mem_cmd_ready : (wg || rw);
        end
    end

    // Monitor: every cycle the command is presented it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (mem_cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got adx %0h expected no command", mem_cmd_adx);
            end else begin
                chk("cmd_write", mem_cmd_write, exp_q[0].write);
                chk("cmd_adx", mem_cmd_adx, exp_q[0].adx);
                if (exp_q[0].write) chk("cmd_data", mem_cmd_data, exp_q[0].data);
                if (mem_cmd_ready) void'(exp_q.pop_front());
            end
        end
    end

    int p_wr = 0, p_rd = 0, p_rdy = 100, p_ret = 0;
    bit force_ret = 0, logging = 0;
    int n_rd_acks = 0;
    bit ack_log[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (wr_req && wr_ack) begin
            wr_req = 1'b0;
            if (logging) ack_log.push_back(1'b1);
        end
        if (rd_req && rd_ack) begin
            rd_req = 1'b0;
            n_rd_acks++;
            if (logging) ack_log.push_back(1'b0);
        end
        if (!wr_req && ($urandom_range(99) < p_wr)) begin
            wr_req  = 1'b1;
            wr_adx  = AW'($urandom);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
        end
        if (!rd_req && ($urandom_range(99) < p_rd)) begin
            rd_req = 1'b1;
            rd_adx = AW'($urandom);
        end
        mem_cmd_ready = ($urandom_range(99) < p_rdy);
        rd_return     = force_ret || ((m_out > 0) && ($urandom_range(99) < p_ret));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rd_return = 1'b0; mem_cmd_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_valid", mem_cmd_valid, 1'b0);
        chk("reset_outstanding", rd_outstanding, 4'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_adx", mem_cmd_adx, '0);
        reset = 1'b0;

        // Single write, ready held high: ack and valid one cycle after sampling.
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_adx = 27'h10; wr_data = 128'hA5A5; mem_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("w1_ack", wr_ack, 1'b1);
        chk("w1_valid", mem_cmd_valid, 1'b1);
        chk("w1_write", mem_cmd_write, 1'b1);
        chk("w1_adx", mem_cmd_adx, 27'h10);
        wr_req = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_idle", mem_cmd_valid, 1'b0);
        chk("w1_ack_pulse", wr_ack, 1'b0);

        // Return with nothing outstanding sets the sticky error.
        do_reset();
        p_wr = 0; p_rd = 0; p_ret = 0;
        force_ret = 1;
        step();
        force_ret = 0;
        step();
        step();
        chk("underflow_err", credit_err, 1'b1);
        chk("underflow_count", rd_outstanding, 4'd0);

        // Both requesters held: eight writes then one read, repeating.
        do_reset();
        p_wr = 100; p_rd = 100; p_rdy = 100; p_ret = 100;
        ack_log.delete();
        logging = 1;
        repeat (90) step();
        logging = 0;
        chk("burst_log_len", ack_log.size() >= 36, 1'b1);
        for (int i = 0; i < ack_log.size(); i++)
            chk("burst_seq", ack_log[i], (i % 9 == 8) ? 1'b0 : 1'b1);

        // Reads only, no returns: credit cap stops issue until one return.
        do_reset();
        p_wr = 0; p_rd = 100; p_rdy = 100; p_ret = 0;
        n_rd_acks = 0;
        repeat (40) step();
        chk("credit_cap_acks", n_rd_acks, RDMX);
        chk("credit_cap_count", rd_outstanding, 4'(RDMX));
        force_ret = 1;
        step();
        force_ret = 0;
        repeat (10) step();
        chk("credit_release_acks", n_rd_acks, RDMX + 1);

        // Randomized traffic, including long ready stalls.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            p_wr  = $urandom_range(10, 95);
            p_rd  = $urandom_range(10, 95);
            p_rdy = (r == 2) ? 8 : $urandom_range(20, 100);
            p_ret = $urandom_range(5, 60);
            repeat (400) step();
        end

        // Reset while a read command is held and another read is in flight.
        p_wr = 0; p_rd = 100; p_rdy = 40; p_ret = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (m_hold && !m_cur_write && (m_out > 0)) found = 1;
        end
        chk("reset_hold_found", found, 1'b1);
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rd_return = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_valid", mem_cmd_valid, 1'b0);
        chk("midreset_outstanding", rd_outstanding, 4'd0);
        chk("midreset_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
